tri_bus_arb: RTL
================

Name: tri_bus_arb

Overview:
- Parametrised successor to the single tristate driver cell: N_CH channels, each WIDTH bits wide, share one tristate bus.
- A round-robin arbiter with registered enables gives at most one channel the bus per cycle.
- A mandatory all-high-Z turnaround cycle separates every change of owner.
- Sits between multiple on-chip masters and a shared inout bus/pad ring.

Parameters:
- N_CH, 4, number of requesting channels (2..16)
- WIDTH, 8, data width per channel and of the bus
- MAX_BEATS, 4, maximum consecutive cycles one grant may hold the bus (1..255)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  N_CH  per-channel bus request, level-sensitive
- din  input  N_CH*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- gnt  output  N_CH  one-hot registered grant; channel k drives the bus while gnt[k]=1
- bus  inout  WIDTH  shared tristate bus
- bus_q  output  WIDTH  value sampled from bus (bus value passed through combinationally)
- busy  output  1  high when state is DRIVE or TURN

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, gnt=0, beat counter=0, round-robin pointer=0, busy=0.
  - All drivers high-Z from the first clk edge where rst_n=0 is sampled.
  - Reset mid-DRIVE releases the bus at that edge; no turnaround cycle is inserted.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If any req bit is set, pick the first set bit at or above ptr (wrapping modulo N_CH).
  - Next cycle: gnt=onehot(winner), state=DRIVE, beat=1. Request-to-drive latency is 1 cycle.
- DRIVE:
  - bus = din slice of the granted channel; every other cell is high-Z.
  - Stay in DRIVE while req[owner]=1 and beat<MAX_BEATS; beat increments each cycle.
  - Leave when req[owner]=0 or beat==MAX_BEATS: next cycle gnt=0, state=TURN, ptr=owner+1 (wraps from N_CH-1 to 0).
- TURN:
  - Exactly one cycle with all drivers high-Z.
  - Next state is IDLE, and arbitration happens in that IDLE cycle.
  - Minimum gap between two owners is therefore 2 cycles (TURN + IDLE); back-to-back re-grant to the same channel takes the same gap.
- Simultaneous requests: the winner is the lowest index at or above ptr. Fairness is guaranteed because ptr advances past each owner.
- Request dropped in the same cycle the grant registers: the channel still drives 1 beat, then TURN.
- Request from the owner while in TURN: ignored until IDLE.
- gnt is never multi-hot. gnt changes only at clk edges, so there is no glitch-driven contention.
- bus_q = bus (combinational). It reads X/Z when undriven, unless the optional feature is enabled.

Optional Feature:
- Macro: TRI_BUS_KEEPER_EN
- Defined:
  - A WIDTH-bit keeper register captures bus on every DRIVE cycle.
  - bus_q outputs the keeper value whenever no gnt bit is set.
  - Keeper resets to 0.
- Not defined: bus_q follows bus directly, and the keeper register is absent.

Decomposition:
- Shared package/include holds:
  - state localparams ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_TURN=2'd2
  - a clog2 function for the widths of ptr and beat.
- Natural sub-module: tri_cell (WIDTH-parametrised tristate driver, out = en ? in : 'bz), instantiated N_CH times via generate.
- Arbiter FSM, round-robin pointer and beat counter live in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, busy=0, bus=Z throughout. First grant goes to ch0 one cycle after rst_n rises.
- Single requester: req=4'b0100, din[ch2]=8'hA5 held for 2 cycles, then dropped -> gnt=4'b0100 for 2 cycles, bus=8'hA5, then 1 TURN cycle with bus=Z, then IDLE.
- MAX_BEATS cap: ch1 holds req for 10 cycles, MAX_BEATS=4 -> ch1 drives 4 cycles, TURN, IDLE, then ch1 re-granted for 4 more beats.
- Round-robin: req=4'b1111 held constant -> grant order ch0, ch1, ch2, ch3, ch0. Each grant lasts 4 beats separated by 2 idle/turn cycles. gnt is always one-hot or zero.
- Reset mid-DRIVE: assert rst_n=0 during beat 2 of ch3 -> at that edge gnt=0, bus=Z, ptr=0, and no TURN cycle.
- Keeper (TRI_BUS_KEEPER_EN defined): ch0 drives 8'h3C and releases -> bus_q holds 8'h3C through TURN and IDLE. With the macro undefined, bus_q=Z in those cycles.

Source files
------------

// File: rtl/tri_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// tri_bus_arb_pkg
// Shared definitions for the tristate bus arbiter:
//   - FSM state encodings (ST_IDLE, ST_DRIVE, ST_TURN)
//   - clog2 helper used to size the round-robin pointer and the beat counter
// -----------------------------------------------------------------------------
package tri_bus_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  // Number of bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tri_bus_arb_cell.sv
// -----------------------------------------------------------------------------
// tri_cell
// One WIDTH-bit tristate driver: pad follows data while en is high,
// otherwise the cell floats its output.
// Ports:
//   en   - drive enable (a registered grant bit)
//   data - value to place on the bus
//   pad  - connection to the shared bus net
// -----------------------------------------------------------------------------
module tri_cell #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output wire  [WIDTH-1:0] pad
);

  assign pad = en ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/tri_bus_arb.sv
// -----------------------------------------------------------------------------
// tri_bus_arb
// N_CH channels share one WIDTH-bit tristate bus. A round-robin arbiter with
// registered one-hot grants hands the bus to at most one channel per cycle,
// with an all-high-Z turnaround cycle between owners.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   req    - per-channel level-sensitive bus request
//   din    - channel data, channel k at [k*WIDTH +: WIDTH]
//   gnt    - one-hot registered grant; gnt[k] means channel k drives bus
//   bus    - shared tristate bus
//   bus_q  - value seen on bus (or held keeper value, see below)
//   busy   - high in DRIVE or TURN
//
// Build option: define TRI_BUS_KEEPER_EN to add a keeper register that
// captures bus on every DRIVE cycle and is presented on bus_q while no
// channel holds a grant. Without it bus_q is bus passed straight through.
// -----------------------------------------------------------------------------
module tri_bus_arb
  import tri_bus_arb_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*WIDTH-1:0] din,
  output logic [N_CH-1:0]       gnt,
  inout  wire  [WIDTH-1:0]      bus,
  output logic [WIDTH-1:0]      bus_q,
  output logic                  busy
);

  localparam int PW = clog2(N_CH);
  localparam int BW = clog2(MAX_BEATS + 1);

  // Request/grant handshake: a channel raises req and holds it for as long as
  // it wants the bus. gnt[k] rises one cycle after arbitration in IDLE and
  // stays up while req[k] is held, up to MAX_BEATS cycles. Dropping req ends
  // the grant at the next edge; a request seen during TURN is only
  // considered once the arbiter is back in IDLE.

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [BW-1:0] beat;

  // Round-robin search: first requesting channel at or above ptr, wrapping.
  logic          found;
  logic [PW-1:0] winner;
  logic [PW:0]   idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N_CH)) idx = idx - (PW+1)'(N_CH);
      if (!found && req[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  // Pointer moves just past the releasing owner so it loses priority next time.
  logic [PW-1:0] ptr_next;
  assign ptr_next = (owner == PW'(N_CH - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      beat  <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state <= ST_DRIVE;
            gnt   <= N_CH'(1) << winner;
            beat  <= BW'(1);
            owner <= winner;
          end
        end
        ST_DRIVE: begin
          if (req[owner] && (beat < BW'(MAX_BEATS))) begin
            beat <= beat + 1'b1;
          end else begin
            state <= ST_TURN;
            gnt   <= '0;
            beat  <= '0;
            ptr   <= ptr_next;
          end
        end
        ST_TURN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          beat  <= '0;
        end
      endcase
    end
  end

  assign busy = (state == ST_DRIVE) || (state == ST_TURN);

  for (genvar k = 0; k < N_CH; k++) begin : g_cell
    tri_cell #(.WIDTH(WIDTH)) u_cell (
      .en   (gnt[k]),
      .data (din[k*WIDTH +: WIDTH]),
      .pad  (bus)
    );
  end

`ifdef TRI_BUS_KEEPER_EN
  logic [WIDTH-1:0] keeper;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keeper <= '0;
    end else if (state == ST_DRIVE) begin
      keeper <= bus;
    end
  end

  assign bus_q = (|gnt) ? bus : keeper;
`else
  assign bus_q = bus;
`endif

endmodule
